// File: rtl/store_commit_drain.sv
// Committed-store drain queue: cacheable stores issue up to PIPE per cycle to the
// commit buffer; an uncached head waits for the buffer to empty and is written directly.
module store_commit_drain #(
  parameter int DEPTH = 8,
  parameter int PIPE  = 2,
  parameter int PADDR = 32,
  parameter int DBYTE = 4,
  localparam int DBITS = 8 * DBYTE,
  localparam int OFF   = $clog2(DBYTE),
  localparam int SADDR = PADDR - OFF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIPE-1:0]        enq_valid,
  input  logic [PIPE*PADDR-1:0]  enq_paddr,
  input  logic [PIPE*DBITS-1:0]  enq_data,
  input  logic [PIPE*DBYTE-1:0]  enq_mask,
  input  logic [PIPE-1:0]        enq_uncache,
  output logic                   enq_ready,
  output logic [PIPE-1:0]        sc_en,
  output logic [PIPE-1:0]        sc_uncache,
  output logic [PIPE*SADDR-1:0]  sc_addr,
  output logic [PIPE*DBYTE-1:0]  sc_mask,
  output logic [PIPE*DBITS-1:0]  sc_data,
  input  logic                   sc_conflict,
  input  logic                   sc_empty,
  output logic                   uc_req_valid,
  input  logic                   uc_req_ready,
  output logic [PADDR-1:0]       uc_req_addr,
  output logic [DBITS-1:0]       uc_req_data,
  output logic [DBYTE-1:0]       uc_req_mask,
  input  logic                   uc_resp_valid,
  output logic [CW-1:0]          count,
  output logic                   empty
);

  localparam int AW = CW - 1;

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, RESP} state_t;

  state_t                   state_reg, state_next;
  logic [AW:0]              head_reg, head_next;
  logic [AW:0]              tail_reg, tail_next;
  logic                     acc_prev_reg;

  logic [PADDR-1:0]         mem_paddr [DEPTH];
  logic [DBITS-1:0]         mem_data  [DEPTH];
  logic [DBYTE-1:0]         mem_mask  [DEPTH];
  logic [DEPTH-1:0]         mem_uncache;

  logic [PIPE-1:0][AW-1:0]  rd_idx;
  logic [PIPE-1:0][AW-1:0]  wr_idx;
  logic [PIPE-1:0]          rd_cacheable;
  logic [PIPE-1:0]          enq_fire;
  logic [AW:0]              n_enq;
  logic [AW:0]              n_deq;
  logic [AW:0]              n_issue;
  logic                     accept;
  logic                     enq_run;
  logic                     iss_run;
  logic [CW:0]              free_slots;

  // Wrap bit in the pointer MSB makes the difference equal to occupancy, full included.
  assign count      = tail_reg - head_reg;
  assign empty      = (head_reg == tail_reg);
  assign free_slots = (CW+1)'(DEPTH) - {1'b0, count};
  assign enq_ready  = (free_slots >= (CW+1)'(PIPE));
  assign sc_uncache = '0;

  generate
    for (genvar gi = 0; gi < PIPE; gi++) begin : g_slot
      assign rd_idx[gi]       = head_reg[AW-1:0] + AW'(gi);
      assign wr_idx[gi]       = tail_reg[AW-1:0] + AW'(gi);
      assign rd_cacheable[gi] = (count > CW'(gi)) && !mem_uncache[rd_idx[gi]];
      assign sc_addr[gi*SADDR +: SADDR] = mem_paddr[rd_idx[gi]][PADDR-1:OFF];
      assign sc_mask[gi*DBYTE +: DBYTE] = mem_mask[rd_idx[gi]];
      assign sc_data[gi*DBITS +: DBITS] = mem_data[rd_idx[gi]];
    end
  endgenerate

  assign uc_req_addr = mem_paddr[rd_idx[0]];
  assign uc_req_data = mem_data[rd_idx[0]];
  assign uc_req_mask = mem_mask[rd_idx[0]];

  // A slot enqueues only when every lower slot does, keeping stores contiguous.
  always_comb begin
    enq_fire = '0;
    n_enq    = '0;
    enq_run  = enq_ready;
    for (int i = 0; i < PIPE; i++) begin
      enq_run     = enq_run && enq_valid[i];
      enq_fire[i] = enq_run;
      n_enq       = n_enq + (AW+1)'(enq_run);
    end
  end

  // Issue stops at the first uncached or empty slot so order is preserved.
  always_comb begin
    sc_en   = '0;
    n_issue = '0;
    iss_run = (state_reg == IDLE);
    for (int i = 0; i < PIPE; i++) begin
      iss_run  = iss_run && rd_cacheable[i];
      sc_en[i] = iss_run;
      n_issue  = n_issue + (AW+1)'(iss_run);
    end
  end

  assign accept = (|sc_en) && !sc_conflict;

  always_comb begin
    n_deq = '0;
    if (accept)
      n_deq = n_issue;
    else if (state_reg == RESP && uc_resp_valid)
      n_deq = (AW+1)'(1);
  end

  assign head_next = head_reg + n_deq;
  assign tail_next = tail_reg + n_enq;

  always_comb begin
    state_next   = state_reg;
    uc_req_valid = 1'b0;
    unique case (state_reg)
      IDLE:  if (count != '0 && mem_uncache[rd_idx[0]]) state_next = DRAIN;
      // Wait one extra cycle after the last accepted beat so it lands in the buffer.
      DRAIN: if (sc_empty && !acc_prev_reg) state_next = REQ;
      REQ: begin
        uc_req_valid = 1'b1;
        if (uc_req_ready) state_next = RESP;
      end
      RESP:  if (uc_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      head_reg     <= '0;
      tail_reg     <= '0;
      acc_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      acc_prev_reg <= accept;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PIPE; i++) begin
      if (enq_fire[i]) begin
        mem_paddr[wr_idx[i]]   <= enq_paddr[i*PADDR +: PADDR];
        mem_data[wr_idx[i]]    <= enq_data[i*DBITS +: DBITS];
        mem_mask[wr_idx[i]]    <= enq_mask[i*DBYTE +: DBYTE];
        mem_uncache[wr_idx[i]] <= enq_uncache[i];
      end
    end
  end

  slot1_without_slot0: assert property (@(posedge clk) disable iff (rst)
    !(enq_valid[1] && !enq_valid[0]));

endmodule

// File: tb/tb_store_commit_drain.sv
// Directed bench for store_commit_drain: table of per-cycle vectors for the cacheable
// path, then hand-written sequences for the uncached drain/request/response path.
module tb_store_commit_drain;

  localparam logic [31:0] DK = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  enq_valid;
  logic [63:0] enq_paddr;
  logic [63:0] enq_data;
  logic [7:0]  enq_mask;
  logic [1:0]  enq_uncache;
  logic        enq_ready;
  logic [1:0]  sc_en;
  logic [1:0]  sc_uncache;
  logic [59:0] sc_addr;
  logic [7:0]  sc_mask;
  logic [63:0] sc_data;
  logic        sc_conflict;
  logic        sc_empty;
  logic        uc_req_valid;
  logic        uc_req_ready;
  logic [31:0] uc_req_addr;
  logic [31:0] uc_req_data;
  logic [3:0]  uc_req_mask;
  logic        uc_resp_valid;
  logic [3:0]  count;
  logic        empty;

  int n_cmp  = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  store_commit_drain dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_paddr(enq_paddr), .enq_data(enq_data),
    .enq_mask(enq_mask), .enq_uncache(enq_uncache), .enq_ready(enq_ready),
    .sc_en(sc_en), .sc_uncache(sc_uncache), .sc_addr(sc_addr),
    .sc_mask(sc_mask), .sc_data(sc_data),
    .sc_conflict(sc_conflict), .sc_empty(sc_empty),
    .uc_req_valid(uc_req_valid), .uc_req_ready(uc_req_ready),
    .uc_req_addr(uc_req_addr), .uc_req_data(uc_req_data), .uc_req_mask(uc_req_mask),
    .uc_resp_valid(uc_resp_valid), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (uc_req_valid && uc_req_ready) hs_cnt <= hs_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0]  ev;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        conf;
    logic        exp_ready;
    logic [1:0]  exp_en;
    logic [3:0]  exp_count;
    logic [29:0] exp_a0;
    logic [29:0] exp_a1;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [1:0] unc);
    enq_valid   = v;
    enq_paddr   = {a1, a0};
    enq_data    = {a1 ^ DK, a0 ^ DK};
    enq_mask    = {4'h3, 4'hF};
    enq_uncache = unc;
  endtask

  int hs_base;

  initial begin
    // ---- vectors: inputs, then expected ready / sc_en / count / slot addresses ----
    vec[0]  = '{2'b11, 32'h1000, 32'h1004, 1'b0, 1'b1, 2'b00, 4'd0, 30'h0,    30'h0};
    vec[1]  = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 2'b11, 4'd2, 30'h400,  30'h401};
    vec[2]  = '{2'b11, 32'h2000, 32'h2008, 1'b0, 1'b1, 2'b00, 4'd0, 30'h0,    30'h0};
    vec[3]  = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b1, 2'b11, 4'd2, 30'h800,  30'h802};
    vec[4]  = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b1, 2'b11, 4'd2, 30'h800,  30'h802};
    vec[5]  = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b1, 2'b11, 4'd2, 30'h800,  30'h802};
    vec[6]  = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 2'b11, 4'd2, 30'h800,  30'h802};
    vec[7]  = '{2'b11, 32'h3000, 32'h3004, 1'b1, 1'b1, 2'b00, 4'd0, 30'h0,    30'h0};
    vec[8]  = '{2'b11, 32'h3008, 32'h300C, 1'b1, 1'b1, 2'b11, 4'd2, 30'hC00,  30'hC01};
    vec[9]  = '{2'b11, 32'h3010, 32'h3014, 1'b1, 1'b1, 2'b11, 4'd4, 30'hC00,  30'hC01};
    vec[10] = '{2'b11, 32'h3018, 32'h301C, 1'b1, 1'b1, 2'b11, 4'd6, 30'hC00,  30'hC01};
    vec[11] = '{2'b11, 32'h4000, 32'h4004, 1'b0, 1'b0, 2'b11, 4'd8, 30'hC00,  30'hC01};
    vec[12] = '{2'b11, 32'h5000, 32'h5004, 1'b0, 1'b1, 2'b11, 4'd6, 30'hC02,  30'hC03};
    vec[13] = '{2'b01, 32'h6000, 32'h0,    1'b1, 1'b1, 2'b11, 4'd6, 30'hC04,  30'hC05};
    vec[14] = '{2'b11, 32'h7000, 32'h7004, 1'b1, 1'b0, 2'b11, 4'd7, 30'hC04,  30'hC05};
    vec[15] = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b0, 2'b11, 4'd7, 30'hC04,  30'hC05};
    vec[16] = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 2'b11, 4'd5, 30'hC06,  30'hC07};
    vec[17] = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 2'b11, 4'd3, 30'h1400, 30'h1401};
    vec[18] = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 2'b01, 4'd1, 30'h1800, 30'h0};
    vec[19] = '{2'b11, 32'h9000, 32'h9004, 1'b0, 1'b1, 2'b00, 4'd0, 30'h0,    30'h0};
    vec[20] = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 2'b11, 4'd2, 30'h2400, 30'h2401};
    vec[21] = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 2'b00, 4'd0, 30'h0,    30'h0};

    // ---- reset ----
    rst = 1'b1;
    drive_enq(2'b00, 32'h0, 32'h0, 2'b00);
    sc_conflict   = 1'b0;
    sc_empty      = 1'b1;
    uc_req_ready  = 1'b0;
    uc_resp_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_sc_en", 64'(sc_en), 64'd0);
    check("rst_uc_req_valid", 64'(uc_req_valid), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    $display("reset: count=%0d empty=%b", count, empty);
    cyc();
    rst = 1'b0;

    // ---- table-driven cacheable path ----
    for (int i = 0; i < NV; i++) begin
      drive_enq(vec[i].ev, vec[i].a0, vec[i].a1, 2'b00);
      sc_conflict = vec[i].conf;
      @(negedge clk);
      check($sformatf("v%0d_enq_ready", i), 64'(enq_ready), 64'(vec[i].exp_ready));
      check($sformatf("v%0d_sc_en", i), 64'(sc_en), 64'(vec[i].exp_en));
      check($sformatf("v%0d_count", i), 64'(count), 64'(vec[i].exp_count));
      check($sformatf("v%0d_empty", i), 64'(empty), 64'(vec[i].exp_count == 4'd0));
      check($sformatf("v%0d_sc_uncache", i), 64'(sc_uncache), 64'd0);
      if (vec[i].exp_en[0]) begin
        check($sformatf("v%0d_addr0", i), 64'(sc_addr[29:0]), 64'(vec[i].exp_a0));
        check($sformatf("v%0d_data0", i), 64'(sc_data[31:0]), 64'({vec[i].exp_a0, 2'b00} ^ DK));
        check($sformatf("v%0d_mask0", i), 64'(sc_mask[3:0]), 64'h F);
      end
      if (vec[i].exp_en[1]) begin
        check($sformatf("v%0d_addr1", i), 64'(sc_addr[59:30]), 64'(vec[i].exp_a1));
        check($sformatf("v%0d_data1", i), 64'(sc_data[63:32]), 64'({vec[i].exp_a1, 2'b00} ^ DK));
        check($sformatf("v%0d_mask1", i), 64'(sc_mask[7:4]), 64'h3);
      end
      $display("vec %0d: enq=%b conf=%b sc_en=%b count=%0d ready=%b",
               i, vec[i].ev, vec[i].conf, sc_en, count, enq_ready);
      cyc();
    end
    drive_enq(2'b00, 32'h0, 32'h0, 2'b00);
    sc_conflict = 1'b0;

    // ---- cacheable, uncached, cacheable with a slow commit buffer ----
    hs_base = hs_cnt;
    drive_enq(2'b11, 32'hA000, 32'h8000_0000, 2'b10);
    sc_empty = 1'b0;
    @(negedge clk);
    check("mix_pre_sc_en", 64'(sc_en), 64'd0);
    cyc();
    drive_enq(2'b01, 32'hA004, 32'h0, 2'b00);
    @(negedge clk);
    check("mix_first_sc_en", 64'(sc_en), 64'b01);
    check("mix_first_addr", 64'(sc_addr[29:0]), 64'h2800);
    cyc();
    drive_enq(2'b00, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    check("mix_blocked_sc_en", 64'(sc_en), 64'd0);
    check("mix_blocked_count", 64'(count), 64'd2);
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("mix_drain%0d_sc_en", k), 64'(sc_en), 64'd0);
      check($sformatf("mix_drain%0d_req", k), 64'(uc_req_valid), 64'd0);
      cyc();
    end
    sc_empty     = 1'b1;
    uc_req_ready = 1'b1;
    @(negedge clk);
    check("mix_drain_exit_req", 64'(uc_req_valid), 64'd0);
    cyc();
    @(negedge clk);
    check("mix_req_valid", 64'(uc_req_valid), 64'd1);
    check("mix_req_addr", 64'(uc_req_addr), 64'h8000_0000);
    check("mix_req_mask", 64'(uc_req_mask), 64'h3);
    cyc();
    uc_req_ready = 1'b0;
    @(negedge clk);
    check("mix_resp_req", 64'(uc_req_valid), 64'd0);
    check("mix_resp_sc_en", 64'(sc_en), 64'd0);
    check("mix_resp_count", 64'(count), 64'd2);
    cyc();
    uc_resp_valid = 1'b1;
    @(negedge clk);
    check("mix_resp_wait_count", 64'(count), 64'd2);
    cyc();
    uc_resp_valid = 1'b0;
    @(negedge clk);
    check("mix_third_sc_en", 64'(sc_en), 64'b01);
    check("mix_third_addr", 64'(sc_addr[29:0]), 64'h2801);
    check("mix_third_count", 64'(count), 64'd1);
    cyc();
    @(negedge clk);
    check("mix_end_count", 64'(count), 64'd0);
    check("mix_uc_handshakes", 64'(hs_cnt - hs_base), 64'd1);
    $display("seq mix: uncached handshakes=%0d count=%0d", hs_cnt - hs_base, count);
    cyc();

    // ---- uncached store with slow request accept and late response ----
    hs_base = hs_cnt;
    drive_enq(2'b01, 32'h8000_0010, 32'h0, 2'b01);
    cyc();
    drive_enq(2'b00, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    check("uc_idle_sc_en", 64'(sc_en), 64'd0);
    cyc();
    @(negedge clk);
    check("uc_drain_req", 64'(uc_req_valid), 64'd0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      uc_req_ready  = (k == 4);
      uc_resp_valid = (k == 1);
      @(negedge clk);
      check($sformatf("uc_req%0d_valid", k), 64'(uc_req_valid), 64'd1);
      check($sformatf("uc_req%0d_addr", k), 64'(uc_req_addr), 64'h8000_0010);
      check($sformatf("uc_req%0d_data", k), 64'(uc_req_data), 64'(32'h8000_0010 ^ DK));
      check($sformatf("uc_req%0d_mask", k), 64'(uc_req_mask), 64'hF);
      check($sformatf("uc_req%0d_count", k), 64'(count), 64'd1);
      cyc();
    end
    uc_req_ready  = 1'b0;
    uc_resp_valid = 1'b0;
    @(negedge clk);
    check("uc_resp_wait_req", 64'(uc_req_valid), 64'd0);
    check("uc_resp_wait_count", 64'(count), 64'd1);
    cyc();
    uc_resp_valid = 1'b1;
    cyc();
    uc_resp_valid = 1'b0;
    @(negedge clk);
    check("uc_done_count", 64'(count), 64'd0);
    check("uc_done_empty", 64'(empty), 64'd1);
    check("uc_handshakes", 64'(hs_cnt - hs_base), 64'd1);
    $display("seq uncached: handshakes=%0d count=%0d", hs_cnt - hs_base, count);
    cyc();

    // ---- reset while waiting for the uncached response ----
    drive_enq(2'b11, 32'h8000_0020, 32'hB000, 2'b01);
    cyc();
    drive_enq(2'b01, 32'hB004, 32'h0, 2'b00);
    @(negedge clk);
    check("rr_sc_en", 64'(sc_en), 64'd0);
    cyc();
    drive_enq(2'b00, 32'h0, 32'h0, 2'b00);
    cyc();
    uc_req_ready = 1'b1;
    @(negedge clk);
    check("rr_req_valid", 64'(uc_req_valid), 64'd1);
    cyc();
    uc_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rr_resp_count", 64'(count), 64'd3);
    check("rr_resp_req", 64'(uc_req_valid), 64'd0);
    cyc();
    rst = 1'b0;
    uc_resp_valid = 1'b1;
    drive_enq(2'b01, 32'hC000, 32'h0, 2'b00);
    @(negedge clk);
    check("rr_count", 64'(count), 64'd0);
    check("rr_empty", 64'(empty), 64'd1);
    check("rr_uc_req_valid", 64'(uc_req_valid), 64'd0);
    check("rr_sc_en", 64'(sc_en), 64'd0);
    cyc();
    uc_resp_valid = 1'b0;
    drive_enq(2'b00, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    check("rr_idle_sc_en", 64'(sc_en), 64'b01);
    check("rr_idle_addr", 64'(sc_addr[29:0]), 64'h3000);
    check("rr_idle_count", 64'(count), 64'd1);
    cyc();
    @(negedge clk);
    check("rr_final_count", 64'(count), 64'd0);
    $display("seq reset-in-resp: count=%0d empty=%b", count, empty);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
